// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU controller: ALUOp classes, Funct7
// patterns, 5-bit operation codes and the MUL/DIV sequencer states.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] OP_AND      = 5'h00;
  localparam logic [4:0] OP_OR       = 5'h01;
  localparam logic [4:0] OP_XOR      = 5'h02;
  localparam logic [4:0] OP_ADD      = 5'h03;
  localparam logic [4:0] OP_SUB      = 5'h04;
  localparam logic [4:0] OP_BEQ      = 5'h05;
  localparam logic [4:0] OP_BNE      = 5'h06;
  localparam logic [4:0] OP_SLT      = 5'h07;
  localparam logic [4:0] OP_SLL      = 5'h08;
  localparam logic [4:0] OP_SRL      = 5'h09;
  localparam logic [4:0] OP_SRA      = 5'h0A;
  localparam logic [4:0] OP_BGE      = 5'h0B;
  localparam logic [4:0] OP_SLTU     = 5'h0E;
  localparam logic [4:0] OP_BGEU     = 5'h0F;
  localparam logic [4:0] OP_MUL_BASE = 5'h10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  // Funct3 map shared by the R-type base row and the I-type ALU row.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational ALUOp/Funct7/Funct3 decode into an operation code plus
// illegal and MUL/DIV class flags.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [1:0] i_aluop,
  input  logic [6:0] i_funct7,
  input  logic [2:0] i_funct3,
  output logic [4:0] o_operation,
  output logic       o_illegal,
  output logic       o_is_muldiv,
  output logic       o_is_div
);

  always_comb begin
    o_operation = OP_ADD;
    o_illegal   = 1'b0;
    o_is_muldiv = 1'b0;
    o_is_div    = 1'b0;
    case (i_aluop)
      ALUOP_MEM: o_operation = OP_ADD;
      ALUOP_BRANCH: begin
        case (i_funct3)
          3'b000:  o_operation = OP_BEQ;
          3'b001:  o_operation = OP_BNE;
          3'b100:  o_operation = OP_SLT;
          3'b101:  o_operation = OP_BGE;
          3'b110:  o_operation = OP_SLTU;
          3'b111:  o_operation = OP_BGEU;
          default: o_illegal   = 1'b1;
        endcase
      end
      ALUOP_RTYPE: begin
        if (i_funct7 == F7_BASE) begin
          o_operation = base_op(i_funct3);
        end else if (i_funct7 == F7_ALT) begin
          if (i_funct3 == 3'b000)      o_operation = OP_SUB;
          else if (i_funct3 == 3'b101) o_operation = OP_SRA;
          else                         o_illegal   = 1'b1;
        end else if (i_funct7 == F7_MULDIV && ENABLE_M != 0) begin
          o_operation = OP_MUL_BASE + {2'b00, i_funct3};
          o_is_muldiv = 1'b1;
          o_is_div    = i_funct3[2];
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: begin
        // Immediate shifts carry the arithmetic flag in instr[30].
        if (i_funct3 == 3'b101) o_operation = i_funct7[5] ? OP_SRA : OP_SRL;
        else                    o_operation = base_op(i_funct3);
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller at the ID/EX boundary with a MUL/DIV sequencer
// that stalls the pipeline for a fixed latency per operation class.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall_in,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  output logic            op_valid,
  output logic [OP_W-1:0] operation,
  output logic            illegal,
  output logic            md_start,
  output logic            busy,
  output logic            md_done
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  logic [4:0]      w_dec_op;
  logic            w_dec_illegal;
  logic            w_is_muldiv;
  logic            w_is_div;
  logic            w_accept;
  logic            w_busy;
  logic            w_md_done;
  logic            w_md_start_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  md_state_e       w_state_nxt;

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  logic             r_op_valid;
  logic [OP_W-1:0]  r_operation;
  logic             r_illegal;

  alu_op_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .i_aluop     (ALUOp),
    .i_funct7    (Funct7),
    .i_funct3    (Funct3),
    .o_operation (w_dec_op),
    .o_illegal   (w_dec_illegal),
    .o_is_muldiv (w_is_muldiv),
    .o_is_div    (w_is_div)
  );

  assign w_busy   = (r_state == ST_MD_BUSY);
  assign w_accept = in_valid & ~stall_in & ~w_busy & ~flush;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_md_start_nxt = 1'b0;
    w_md_done      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_muldiv) begin
            w_state_nxt    = ST_MD_BUSY;
            w_cnt_nxt      = w_is_div ? DIV_LOAD : MUL_LOAD;
            w_md_start_nxt = 1'b1;
          end
        end
        default: begin
          // The M-unit runs on its own; stall_in does not pause the count.
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_md_done   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_md_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_md_start <= w_md_start_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_valid  <= 1'b0;
      r_operation <= OP_W'(OP_ADD);
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_op_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_op_valid  <= 1'b1;
      r_operation <= OP_W'(w_dec_op);
      r_illegal   <= w_dec_illegal;
    end else if (!stall_in && !w_busy) begin
      r_op_valid <= 1'b0;
    end
  end

  assign op_valid  = r_op_valid;
  assign operation = r_operation;
  assign illegal   = r_illegal;
  assign md_start  = r_md_start;
  assign busy      = w_busy;
  assign md_done   = w_md_done;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomised and directed bench for alu_ctrl_seq against a cycle-count
// reference model of the controller.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
  localparam int BASE_OP [8] = '{3, 8, 7, 14, 2, 9, 1, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, stall_in, flush;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       op_valid;
  logic [4:0] operation;
  logic       illegal, md_start, busy, md_done;

  int checks = 0;
  int errors = 0;

  bit m_valid, m_ill, m_start;
  int m_op, m_left;

  alu_ctrl_seq #(
    .OP_W(5), .ENABLE_M(1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall_in(stall_in),
    .flush(flush), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .op_valid(op_valid), .operation(operation), .illegal(illegal),
    .md_start(md_start), .busy(busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [1:0] a, input logic [6:0] f7,
                                     input logic [2:0] f3, output int op,
                                     output bit ill, output int lat);
    op = 3; ill = 1'b0; lat = 0;
    if (a == 2'b01) begin
      if (f3 == 3'd0) op = 5;
      else if (f3 == 3'd1) op = 6;
      else if (f3 == 3'd4) op = 7;
      else if (f3 == 3'd5) op = 11;
      else if (f3 == 3'd6) op = 14;
      else if (f3 == 3'd7) op = 15;
      else ill = 1'b1;
    end else if (a == 2'b10) begin
      if (f7 == 7'h00) op = BASE_OP[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 4;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 10;
      else if (f7 == 7'h01) begin
        op  = 16 + int'(f3);
        lat = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
      end else ill = 1'b1;
    end else if (a == 2'b11) begin
      if (f3 == 3'd5) op = f7[5] ? 10 : 9;
      else op = BASE_OP[f3];
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ill = 1'b0; m_op = 3; m_left = 0; m_start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic s, input logic f,
                       input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3);
    in_valid = v; stall_in = s; flush = f; ALUOp = a; Funct7 = f7; Funct3 = f3;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic step();
    bit busy_now, ill;
    int op, lat;
    busy_now = (m_left > 0);
    ref_decode(ALUOp, Funct7, Funct3, op, ill, lat);
    m_start = 1'b0;
    if (flush) begin
      m_valid = 1'b0; m_ill = 1'b0; m_left = 0;
    end else if (busy_now) begin
      m_left--;
    end else if (in_valid && !stall_in) begin
      m_valid = 1'b1; m_op = op; m_ill = ill;
      if (lat > 0) begin m_left = lat; m_start = 1'b1; end
    end else if (!stall_in) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %0b want 0", op_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (operation !== 5'h03) begin errors++; $display("FAIL reset_operation: got %02h want 03", operation); end
    checks++; if ({illegal, md_start, md_done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %03b want 000", {illegal, md_start, md_done});
    end
    reset = 1'b0;
  endtask

  logic [1:0] d_a  [9] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10};
  logic [6:0] d_f7 [9] = '{7'h20, 7'h00, 7'h20, 7'h00, 7'h20, 7'h20, 7'h7F, 7'h00, 7'h05};
  logic [2:0] d_f3 [9] = '{3'd0, 3'd5, 3'd5, 3'd3, 3'd1, 3'd1, 3'd7, 3'd3, 3'd0};
  logic [4:0] d_op [9] = '{5'h04, 5'h0B, 5'h0A, 5'h03, 5'h08, 5'h03, 5'h03, 5'h0E, 5'h03};
  logic       d_il [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic test_decode();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, d_a[i], d_f7[i], d_f3[i]);
      step();
      checks++; if (operation !== d_op[i] || illegal !== d_il[i] || op_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL decode_%0d: got op=%02h ill=%0b vld=%0b busy=%0b want op=%02h ill=%0b vld=1 busy=0",
                 i, operation, illegal, op_valid, busy, d_op[i], d_il[i]);
      end
    end
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    step();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL decode_idle_clear: got %0b want 0", op_valid); end
  endtask

  task automatic test_mul();
    int nb = 0, nd = 0, ns = 0;
    drive(1, 0, 0, 2'b10, 7'h01, 3'b000);
    step();
    checks++; if (operation !== 5'h10 || op_valid !== 1'b1) begin
      errors++; $display("FAIL mul_op: got op=%02h vld=%0b want op=10 vld=1", operation, op_valid);
    end
    drive(1, 0, 0, 2'b00, 7'h00, 3'b000);
    for (int i = 0; i < 10 && busy === 1'b1; i++) begin
      nb++;
      if (md_done === 1'b1) nd++;
      if (md_start === 1'b1) ns++;
      checks++; if (md_done !== (nb == MUL_LAT)) begin
        errors++; $display("FAIL mul_done_cycle: busy cycle %0d got md_done=%0b", nb, md_done);
      end
      step();
    end
    checks++; if (nb !== MUL_LAT || nd !== 1 || ns !== 1) begin
      errors++; $display("FAIL mul_pulses: got busy=%0d done=%0d start=%0d want %0d/1/1", nb, nd, ns, MUL_LAT);
    end
    checks++; if (operation !== 5'h10) begin errors++; $display("FAIL mul_hold: got %02h want 10", operation); end
    step();
    checks++; if (operation !== 5'h03 || op_valid !== 1'b1) begin
      errors++; $display("FAIL mul_next_accept: got op=%02h vld=%0b want op=03 vld=1", operation, op_valid);
    end
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    step();
  endtask

  task automatic test_div_stall();
    int nb = 0, nd = 0;
    drive(1, 0, 0, 2'b10, 7'h01, 3'b100);
    step();
    checks++; if (operation !== 5'h14) begin errors++; $display("FAIL div_op: got %02h want 14", operation); end
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    for (int i = 1; i <= 60 && busy === 1'b1; i++) begin
      nb++;
      if (md_done === 1'b1) nd++;
      stall_in = (i >= 5 && i <= 10);
      step();
    end
    stall_in = 1'b0;
    checks++; if (nb !== DIV_LAT || nd !== 1) begin
      errors++; $display("FAIL div_stall_len: got busy=%0d done=%0d want %0d/1", nb, nd, DIV_LAT);
    end
    step();
  endtask

  task automatic test_flush();
    int nd = 0;
    drive(1, 0, 0, 2'b10, 7'h01, 3'b110);
    step();
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    repeat (6) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %0b want 1", busy); end
    drive(1, 0, 1, 2'b00, 7'h00, 3'b000);
    step();
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    checks++; if (busy !== 1'b0 || op_valid !== 1'b0 || illegal !== 1'b0 || md_start !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got busy=%0b vld=%0b ill=%0b start=%0b want 0000",
                         busy, op_valid, illegal, md_start);
    end
    for (int i = 0; i < 40; i++) begin
      if (md_done === 1'b1 || busy === 1'b1) nd++;
      step();
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL flush_no_done: got %0d busy/done cycles want 0", nd); end
  endtask

  task automatic test_stall_hold();
    drive(1, 0, 0, 2'b10, 7'h00, 3'b100);
    step();
    checks++; if (operation !== 5'h02 || op_valid !== 1'b1) begin
      errors++; $display("FAIL stall_setup: got op=%02h vld=%0b want 02/1", operation, op_valid);
    end
    drive(1, 1, 0, 2'b00, 7'h00, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (operation !== 5'h02 || op_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d: got op=%02h vld=%0b want 02/1", i, operation, op_valid);
      end
    end
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    step();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b want 0", op_valid); end
  endtask

  task automatic test_reset_mid_mul();
    drive(1, 0, 0, 2'b10, 7'h01, 3'b001);
    step();
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got busy=%0b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || op_valid !== 1'b0 || operation !== 5'h03 || md_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got busy=%0b vld=%0b op=%02h start=%0b want 0/0/03/0",
                         busy, op_valid, operation, md_start);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] f7;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0),
            2'($urandom), f7, 3'($urandom));
      step();
      checks++;
      if (op_valid !== m_valid || illegal !== m_ill || busy !== (m_left > 0) || md_start !== m_start ||
          md_done !== (m_left == 1 && !flush) || (m_valid && operation !== 5'(m_op))) begin
        errors++;
        $display("FAIL random_%0d: got vld=%0b op=%02h ill=%0b busy=%0b start=%0b done=%0b want vld=%0b op=%02h ill=%0b left=%0d start=%0b",
                 i, op_valid, operation, illegal, busy, md_start, md_done, m_valid, m_op, m_ill, m_left, m_start);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 7'h00, 3'b000);
    model_reset();
    test_reset();
    test_decode();
    test_mul();
    test_div_stall();
    test_flush();
    test_stall_hold();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
